// File: rtl/bit_permute_pkg.sv
// Shared types and bit-permutation helpers for the bit_permute_pipe block.
// Helpers work on a MAX_W-bit container; callers zero-extend and truncate to their own width.
package bit_permute_pkg;

    localparam int TAG_W = 4;
    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        BP_PASS  = 2'd0,
        BP_REV   = 2'd1,
        BP_GREV  = 2'd2,
        BP_GSWAP = 2'd3
    } bp_mode_e;

    function automatic logic bpIsPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic logic [MAX_W-1:0] bpReverse(input logic [MAX_W-1:0] d, input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) r[i] = d[width-1-i];
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bpGroupReverse(input logic [MAX_W-1:0] d, input int width,
                                                        input int group);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) r[i] = d[(i - (i % group)) + (group - 1 - (i % group))];
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bpGroupSwap(input logic [MAX_W-1:0] d, input int width,
                                                     input int group);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) r[i] = d[((width / group) - 1 - (i / group)) * group + (i % group)];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_permute_pipe_stage.sv
// bp_stage: one valid/ready register slice that loads when empty or when its contents leave.
module bp_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_load;

    // Holding rst_n low also blocks upstream handshakes through this slice.
    assign in_ready = rst_n && (!r_valid || out_ready);
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: rtl/bit_permute_pipe.sv
// bit_permute_pipe: two-stage valid/ready pipe applying pass, reverse, group-reverse or group-swap.
// S1 registers the raw operand; the permutation sits between S1 and S2.
module bit_permute_pipe
    import bit_permute_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      done_count
);

    localparam int S1_W = WIDTH + 2 + TAG_W;
    localparam int S2_W = WIDTH + TAG_W;

    if (!bpIsPow2(WIDTH) || !bpIsPow2(GROUP) || (WIDTH % GROUP) != 0 || WIDTH < 8 ||
        GROUP > WIDTH || WIDTH > MAX_W) begin : g_badParams
        $error("bit_permute_pipe: WIDTH and GROUP must be powers of two with GROUP dividing WIDTH");
    end

    logic             w_s1Valid;
    logic             w_s2InReady;
    logic [S1_W-1:0]  w_s1Bus;
    logic [WIDTH-1:0] w_s1Data;
    bp_mode_e         w_s1Mode;
    logic [TAG_W-1:0] w_s1Tag;
    logic [MAX_W-1:0] w_s1DataExt;
    logic [WIDTH-1:0] w_perm;
    logic [S2_W-1:0]  w_s2Bus;
    logic             w_outFire;
    logic [31:0]      w_countNext;
    logic [31:0]      r_doneCount;

    bp_stage #(.DW(S1_W)) u_stage1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_tag, in_mode, in_data}),
        .out_valid(w_s1Valid),
        .out_ready(w_s2InReady),
        .out_data (w_s1Bus)
    );

    assign w_s1Data    = w_s1Bus[WIDTH-1:0];
    assign w_s1Mode    = bp_mode_e'(w_s1Bus[WIDTH +: 2]);
    assign w_s1Tag     = w_s1Bus[S1_W-1 -: TAG_W];
    assign w_s1DataExt = MAX_W'(w_s1Data);

    always_comb begin
        w_perm = w_s1Data;
        case (w_s1Mode)
            BP_REV:   w_perm = WIDTH'(bpReverse(w_s1DataExt, WIDTH));
            BP_GREV:  w_perm = WIDTH'(bpGroupReverse(w_s1DataExt, WIDTH, GROUP));
            BP_GSWAP: w_perm = WIDTH'(bpGroupSwap(w_s1DataExt, WIDTH, GROUP));
            default:  w_perm = w_s1Data;
        endcase
    end

    bp_stage #(.DW(S2_W)) u_stage2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_s1Valid),
        .in_ready (w_s2InReady),
        .in_data  ({w_s1Tag, w_perm}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_s2Bus)
    );

    assign out_data = w_s2Bus[WIDTH-1:0];
    assign out_tag  = w_s2Bus[S2_W-1 -: TAG_W];

    // The counter is rewritten every cycle so it always tracks its own current value.
    assign w_outFire   = out_valid && out_ready;
    assign w_countNext = (w_outFire && (r_doneCount != 32'hFFFF_FFFF)) ? r_doneCount + 32'd1
                                                                       : r_doneCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_doneCount <= '0;
        end else begin
            r_doneCount <= w_countNext;
        end
    end

    assign done_count = r_doneCount;

endmodule
